// File: rtl/cipher_if.sv
// cipher_if: request/result bundle between the message buffer side and the cipher engine.
interface cipher_if #(parameter int MSG_LEN = 6, parameter int SEC_LEN = 3);
  logic                   start;
  logic                   mode;
  logic [8*SEC_LEN-1:0]   key;
  logic [8*MSG_LEN-1:0]   text_in;
  logic [8*MSG_LEN-1:0]   text_out;
  logic [MSG_LEN-1:0]     invalid;
  logic                   busy;
  logic                   done;
  modport master (output start, mode, key, text_in, input text_out, invalid, busy, done);
  modport slave  (input start, mode, key, text_in, output text_out, invalid, busy, done);
endinterface

// File: rtl/encryptor_decryptor.sv
// encryptor_decryptor: keyed 64-symbol substitution cipher, one character per clock.
// Define CIPHER_STRICT_EN to zero invalid characters instead of passing them through.
module encryptor_decryptor #(
  parameter int MSG_LEN = 6,
  parameter int SEC_LEN = 3
) (
  input logic     clk,
  input logic     rst_n,
  cipher_if.slave bus
);
  localparam int IW = MSG_LEN > 1 ? $clog2(MSG_LEN) : 1;
  localparam int KW = SEC_LEN > 1 ? $clog2(SEC_LEN) : 1;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
  state_t               state, next;
  logic [IW-1:0]        idx;
  logic [KW-1:0]        kidx;
  logic [8*MSG_LEN-1:0] text_r;
  logic [8*SEC_LEN-1:0] key_r;
  logic                 mode_r;
  logic [7:0]           c, kc, p, q, res, bad_byte;
  logic [5:0]           sum;
  logic                 bad;

  function automatic logic [7:0] get_position(input logic [7:0] ch);
    if (ch >= "A" && ch <= "Z") return ch - 8'd65;
    if (ch >= "a" && ch <= "z") return ch - 8'd71;
    if (ch >= "0" && ch <= "9") return ch + 8'd4;
    if (ch == " ") return 8'd62;
    if (ch == ".") return 8'd63;
    return 8'hFF;
  endfunction

  function automatic logic [7:0] alpha(input logic [5:0] n);
    return n < 6'd26 ? {2'b00, n} + 8'd65 :
           n < 6'd52 ? {2'b00, n} + 8'd71 :
           n < 6'd62 ? {2'b00, n} - 8'd4  :
           n == 6'd62 ? 8'h20 : 8'h2E;
  endfunction

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= next;

  always_comb begin
    next = state == S_IDLE ? (bus.start ? S_RUN : S_IDLE) :
           state == S_RUN  ? (idx == IW'(MSG_LEN - 1) ? S_FIN : S_RUN) : S_IDLE;
  end

  always_comb begin
    bus.busy = state == S_RUN;
  end

`ifdef CIPHER_STRICT_EN
  assign bad_byte = 8'h00;
`else
  assign bad_byte = c;
`endif

  // Modulo-64 wrap falls out of the 6-bit sum for both directions.
  always_comb begin
    c   = text_r[idx*8 +: 8];
    kc  = key_r[kidx*8 +: 8];
    p   = get_position(c);
    q   = get_position(kc);
    bad = p == 8'hFF || q == 8'hFF;
    sum = mode_r ? p[5:0] - q[5:0] : p[5:0] + q[5:0];
    res = bad ? bad_byte : alpha(sum);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx          <= '0;
      kidx         <= '0;
      text_r       <= '0;
      key_r        <= '0;
      mode_r       <= 1'b0;
      bus.text_out <= '0;
      bus.invalid  <= '0;
      bus.done     <= 1'b0;
    end else begin
      bus.done <= state == S_FIN;
      if (state == S_IDLE && bus.start) begin
        text_r <= bus.text_in;
        key_r  <= bus.key;
        mode_r <= bus.mode;
        idx    <= '0;
        kidx   <= '0;
      end else if (state == S_RUN) begin
        bus.text_out[idx*8 +: 8] <= res;
        bus.invalid[idx]         <= bad;
        idx                      <= idx + 1'b1;
        kidx                     <= kidx == KW'(SEC_LEN - 1) ? '0 : kidx + 1'b1;
      end
    end
endmodule

// File: tb/tb_encryptor_decryptor.sv
// tb_encryptor_decryptor: scoreboard bench for the cipher engine (MSG_LEN 6, SEC_LEN 3).
module tb_encryptor_decryptor;
  localparam int ML = 6;
  localparam int SL = 3;
  typedef struct {
    logic [8*ML-1:0] text;
    logic [ML-1:0]   inv;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  string alpha_s = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789 .";

  always #5 clk = ~clk;

  cipher_if #(.MSG_LEN(ML), .SEC_LEN(SL)) bus();
  encryptor_decryptor #(.MSG_LEN(ML), .SEC_LEN(SL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic logic [8*ML-1:0] pk(input string s);
    logic [8*ML-1:0] r = '0;
    for (int i = 0; i < ML; i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  function automatic logic [8*SL-1:0] pkk(input string s);
    logic [8*SL-1:0] r = '0;
    for (int i = 0; i < SL; i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  function automatic int bpos(input logic [7:0] ch);
    for (int i = 0; i < 64; i++) if (alpha_s[i] == ch) return i;
    return -1;
  endfunction

  function automatic exp_t model(input logic m, input logic [8*SL-1:0] k, input logic [8*ML-1:0] t);
    exp_t r;
    int   p, q;
    r.text = '0;
    r.inv  = '0;
    for (int i = 0; i < ML; i++) begin
      p = bpos(t[8*i +: 8]);
      q = bpos(k[8*(i % SL) +: 8]);
      if (p < 0 || q < 0) begin
        r.inv[i] = 1'b1;
`ifdef CIPHER_STRICT_EN
        r.text[8*i +: 8] = 8'h00;
`else
        r.text[8*i +: 8] = t[8*i +: 8];
`endif
      end else r.text[8*i +: 8] = alpha_s[m ? (p - q + 64) % 64 : (p + q) % 64];
    end
    return r;
  endfunction

  task automatic drive(input logic m, input logic [8*SL-1:0] k, input logic [8*ML-1:0] t);
    @(negedge clk);
    bus.mode    = m;
    bus.key     = k;
    bus.text_in = t;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.done !== 1'b1) n = -1;
  endtask

  task automatic run_txn(input string name, input logic m, input logic [8*SL-1:0] k, input logic [8*ML-1:0] t);
    int   n;
    exp_t e;
    drive(m, k, t);
    wait_done(n);
    e = sb.pop_front();
    checks++;
    if (n != ML + 1) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, want %0d", name, n, ML + 1);
    end
    checks++;
    if (bus.text_out !== e.text) begin
      errors++;
      $display("FAIL %s_text: got %h, want %h", name, bus.text_out, e.text);
    end
    checks++;
    if (bus.invalid !== e.inv) begin
      errors++;
      $display("FAIL %s_invalid: got %b, want %b", name, bus.invalid, e.inv);
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({bus.text_out, bus.invalid, bus.busy, bus.done} !== '0) begin
      errors++;
      $display("FAIL reset_values: got text %h inv %b busy %b done %b, want all 0",
               bus.text_out, bus.invalid, bus.busy, bus.done);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_encrypt;
    int n;
    exp_t e;
    sb.push_back('{pk("RIjVSN"), '0});
    drive(1'b0, pkk("KEY"), pk("HELLO1"));
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL enc_busy: got %b, want 1", bus.busy);
    end
    wait_done(n);
    e = sb.pop_front();
    checks++;
    if (n != ML + 1) begin
      errors++;
      $display("FAIL enc_latency: got %0d cycles, want %0d", n, ML + 1);
    end
    checks++;
    if (bus.text_out !== e.text || bus.invalid !== e.inv) begin
      errors++;
      $display("FAIL enc_result: got %h/%b, want %h/%b", bus.text_out, bus.invalid, e.text, e.inv);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL enc_busy_at_done: got %b, want 0", bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL enc_done_pulse: got %b, want 0", bus.done);
    end
  endtask

  task automatic test_decrypt;
    sb.push_back('{pk("HELLO1"), '0});
    run_txn("dec", 1'b1, pkk("KEY"), pk("RIjVSN"));
  endtask

  task automatic test_invalid;
`ifdef CIPHER_STRICT_EN
    sb.push_back('{'0, '1});
`else
    sb.push_back('{pk("@#$%^&"), '1});
`endif
    run_txn("inv", 1'b0, pkk("KEY"), pk("@#$%^&"));
  endtask

  task automatic test_wrap;
    sb.push_back('{pk("JJJJJJ"), '0});
    run_txn("wrap_enc", 1'b0, pkk("KKK"), pk("......"));
    sb.push_back('{pk("222222"), '0});
    run_txn("wrap_dec", 1'b1, pkk("KKK"), pk("AAAAAA"));
  endtask

  task automatic test_roundtrip;
    logic [8*ML-1:0] t, ct;
    logic [8*SL-1:0] k;
    exp_t e;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < ML; i++) t[8*i +: 8] = alpha_s[$urandom_range(0, 63)];
      for (int i = 0; i < SL; i++) k[8*i +: 8] = alpha_s[$urandom_range(0, 63)];
      if (r == 3) t[15:8] = 8'h7E;
      e = model(1'b0, k, t);
      ct = e.text;
      sb.push_back(e);
      run_txn("rt_enc", 1'b0, k, t);
      sb.push_back(model(1'b1, k, ct));
      run_txn("rt_dec", 1'b1, k, ct);
      if (r != 3) begin
        checks++;
        if (bus.text_out !== t) begin
          errors++;
          $display("FAIL rt_identity: got %h, want %h", bus.text_out, t);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    drive(1'b0, pkk("KEY"), pk("WORLD."));
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.text_out, bus.invalid, bus.busy, bus.done} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got text %h inv %b busy %b done %b, want all 0",
               bus.text_out, bus.invalid, bus.busy, bus.done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{pk("RIjVSN"), '0});
    run_txn("after_reset", 1'b0, pkk("KEY"), pk("HELLO1"));
  endtask

  task automatic test_busy_start;
    int n, extra;
    exp_t e;
    sb.push_back('{pk("RIjVSN"), '0});
    drive(1'b0, pkk("KEY"), pk("HELLO1"));
    repeat (2) @(negedge clk);
    bus.start   = 1'b1;
    bus.mode    = 1'b1;
    bus.text_in = pk("ZZZZZZ");
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n);
    e = sb.pop_front();
    checks++;
    if (n != ML - 2) begin
      errors++;
      $display("FAIL busy_latency: got %0d cycles, want %0d", n, ML - 2);
    end
    checks++;
    if (bus.text_out !== e.text) begin
      errors++;
      $display("FAIL busy_text: got %h, want %h", bus.text_out, e.text);
    end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL busy_second_done: got %0d extra pulses, want 0", extra);
    end
  endtask

  task automatic test_back_to_back;
    int   t[$];
    exp_t e;
    sb.push_back('{pk("RIjVSN"), '0});
    sb.push_back(model(1'b0, pkk("KEY"), pk("WORLD.")));
    @(negedge clk);
    bus.mode    = 1'b0;
    bus.key     = pkk("KEY");
    bus.text_in = pk("HELLO1");
    bus.start   = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 2) bus.text_in = pk("WORLD.");
      if (k == 9) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        t.push_back(k - 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checks++;
          if (bus.text_out !== e.text) begin
            errors++;
            $display("FAIL b2b_text: got %h, want %h", bus.text_out, e.text);
          end
        end
      end
    end
    checks++;
    if (t.size() != 2 || t[0] != ML + 1 || t[1] != 2 * ML + 3) begin
      errors++;
      $display("FAIL b2b_timing: got %0d pulses (first %0d, second %0d), want 2 at %0d and %0d",
               t.size(), t.size() > 0 ? t[0] : -1, t.size() > 1 ? t[1] : -1, ML + 1, 2 * ML + 3);
    end
    sb.delete();
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.mode    = 1'b0;
    bus.key     = '0;
    bus.text_in = '0;
    test_reset();
    test_encrypt();
    test_decrypt();
    test_invalid();
    test_wrap();
    test_roundtrip();
    test_reset_mid();
    test_busy_start();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
